output_argmax: RTL and testbench

Downstream classifier stage for the NOUT second-layer cells. It captures each cell's signed `output_neuron` when that cell pulses `end_state2`. Once all NOUT cells have reported, it scans the captured values serially and reports the index of the largest one as the predicted digit. It also compares the prediction with the target label and, optionally, keeps running accuracy counters for the test loop.

---
 rtl/output_argmax.sv | 170 +++++++++++++++++
 tb/tb_output_argmax.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_argmax.sv
// Argmax stage for the second-layer output cells: captures each cell's value, scans serially for the maximum.
// Optional feature macro: ACCURACY_COUNT_EN (running image/correct counters).
module output_argmax #(
  parameter int NWBITS     = 16,
  parameter int COUNT_BIT1 = 10,
  parameter int COUNT_BIT2 = 8,
  parameter int NOUT       = 10,
  parameter int CNTBITS    = 14,
  localparam int OWBITS    = 2*NWBITS + COUNT_BIT1 + COUNT_BIT2
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [NOUT*OWBITS-1:0]   output_neuron_bus,
  input  logic [NOUT-1:0]          end_state2,
  input  logic [3:0]               target_label,
  input  logic                     clear_count,
  output logic [3:0]               predicted_label,
  output logic [OWBITS-1:0]        max_value,
  output logic                     correct,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic [CNTBITS-1:0]       correct_count,
  output logic [CNTBITS-1:0]       image_count
);

  localparam int IDXW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NOUT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_SCAN    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]               state_reg, state_next;
  logic [IDXW-1:0]          idx_reg;
  logic [IDXW-1:0]          arg_reg, arg_next;
  logic [3:0]               label_reg;
  logic signed [OWBITS-1:0] max_reg, max_next;
  logic signed [OWBITS-1:0] scan_value;
  logic signed [OWBITS-1:0] cell_value [NOUT];
  logic [NOUT-1:0]          flag_vec;
  logic                     accept, start_scan, scan_last, correct_next;

  assign accept     = (state_reg == ST_IDLE) || (state_reg == ST_COLLECT);
  // Captures on the completing edge still land in the buffers while the flags clear.
  assign start_scan = accept && (&(flag_vec | end_state2));
  assign scan_last  = (state_reg == ST_SCAN) && (idx_reg == LAST_IDX);
  assign busy       = (state_reg == ST_SCAN) || (state_reg == ST_DONE);

  generate
    for (genvar gi = 0; gi < NOUT; gi++) begin : g_cell
      logic signed [OWBITS-1:0] value_reg;
      logic                     flag_reg;

      always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
          value_reg <= '0;
          flag_reg  <= 1'b0;
        end else begin
          if (accept && end_state2[gi])
            value_reg <= output_neuron_bus[gi*OWBITS +: OWBITS];
          if (start_scan)
            flag_reg <= 1'b0;
          else if (accept && end_state2[gi])
            flag_reg <= 1'b1;
        end
      end

      assign cell_value[gi] = value_reg;
      assign flag_vec[gi]   = flag_reg;
    end
  endgenerate

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    scan_value = cell_value[idx_reg];
    max_next   = max_reg;
    arg_next   = arg_reg;
    if (idx_reg == '0) begin
      max_next = scan_value;
      arg_next = '0;
    end else if (scan_value > max_reg) begin
      max_next = scan_value;
      arg_next = idx_reg;
    end
  end

  assign correct_next = (4'(arg_next) == label_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_COLLECT: begin
        if (start_scan)
          state_next = ST_SCAN;
        else if (|end_state2)
          state_next = ST_COLLECT;
      end
      ST_SCAN: begin
        if (idx_reg == LAST_IDX)
          state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      arg_reg         <= '0;
      max_reg         <= '0;
      label_reg       <= '0;
      predicted_label <= '0;
      max_value       <= '0;
      correct         <= 1'b0;
      result_valid    <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      result_valid <= scan_last;
      if (start_scan) begin
        label_reg <= target_label;
        idx_reg   <= '0;
      end
      if (state_reg == ST_SCAN) begin
        max_reg <= max_next;
        arg_reg <= arg_next;
        idx_reg <= idx_reg + IDXW'(1);
      end
      if (scan_last) begin
        predicted_label <= 4'(arg_next);
        max_value       <= max_next;
        correct         <= correct_next;
      end
      if (!accept && (|end_state2))
        overrun <= 1'b1;
    end
  end

`ifdef ACCURACY_COUNT_EN
  localparam logic [CNTBITS-1:0] CNT_MAX = '1;
  logic [CNTBITS-1:0] image_count_reg, correct_count_reg;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      image_count_reg   <= '0;
      correct_count_reg <= '0;
    end else if (clear_count) begin
      image_count_reg   <= '0;
      correct_count_reg <= '0;
    end else if (scan_last) begin
      if (image_count_reg != CNT_MAX)
        image_count_reg <= image_count_reg + CNTBITS'(1);
      if (correct_next && (correct_count_reg != CNT_MAX))
        correct_count_reg <= correct_count_reg + CNTBITS'(1);
    end
  end

  assign image_count   = image_count_reg;
  assign correct_count = correct_count_reg;
`else
  logic unused_clear_count;
  assign unused_clear_count = clear_count;
  assign image_count        = '0;
  assign correct_count      = '0;
`endif

endmodule

// File: tb/tb_output_argmax.sv
// Randomized scoreboard bench for output_argmax; expected results come from a direct argmax over the driven values.
module tb_output_argmax;

  localparam int NOUT    = 10;
  localparam int OWBITS  = 50;
  localparam int CNTBITS = 14;

  logic                   clk = 1'b0;
  logic                   reset_b;
  logic [NOUT*OWBITS-1:0] output_neuron_bus;
  logic [NOUT-1:0]        end_state2;
  logic [3:0]             target_label;
  logic                   clear_count;
  logic [3:0]             predicted_label;
  logic [OWBITS-1:0]      max_value;
  logic                   correct;
  logic                   result_valid;
  logic                   busy;
  logic                   overrun;
  logic [CNTBITS-1:0]     correct_count;
  logic [CNTBITS-1:0]     image_count;

  always #5 clk = ~clk;

  output_argmax dut (
    .clk               (clk),
    .reset_b           (reset_b),
    .output_neuron_bus (output_neuron_bus),
    .end_state2        (end_state2),
    .target_label      (target_label),
    .clear_count       (clear_count),
    .predicted_label   (predicted_label),
    .max_value         (max_value),
    .correct           (correct),
    .result_valid      (result_valid),
    .busy              (busy),
    .overrun           (overrun),
    .correct_count     (correct_count),
    .image_count       (image_count)
  );

  typedef struct {
    logic [3:0]        label;
    logic [OWBITS-1:0] maxv;
    logic              corr;
    int                img;
    int                ccnt;
    longint            cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint last_e0 = 0;
  int     model_img = 0;
  int     model_corr = 0;
  logic signed [OWBITS-1:0] img_val [NOUT];

  always @(posedge clk) cyc <= cyc + 64'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every result_valid cycle must match the oldest pending expectation.
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_valid actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("predicted_label", 64'(predicted_label), 64'(mon_e.label));
        chk("max_value", 64'(max_value), 64'(mon_e.maxv));
        chk("correct", 64'(correct), 64'(mon_e.corr));
        chk("image_count", 64'(image_count), 64'(mon_e.img));
        chk("correct_count", 64'(correct_count), 64'(mon_e.ccnt));
        chk("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
        $display("result pred=%0d max=%0d correct=%0b images=%0d corrects=%0d cycle=%0d",
                 predicted_label, $signed(max_value), correct, image_count, correct_count, cyc);
      end
    end
  end

  function automatic int ref_argmax();
    int best = 0;
    for (int i = 1; i < NOUT; i++)
      if (img_val[i] > img_val[best]) best = i;
    return best;
  endfunction

  task automatic pulse_cells(input logic [NOUT-1:0] mask);
    @(negedge clk);
    for (int i = 0; i < NOUT; i++)
      output_neuron_bus[i*OWBITS +: OWBITS] = img_val[i];
    end_state2 = mask;
    @(posedge clk);
    #1;
    end_state2 = '0;
    last_e0 = cyc;
  endtask

  task automatic expect_result(input logic [3:0] tgt, input bit clr);
    exp_t e;
    int a;
    a = ref_argmax();
    e.label = 4'(a);
    e.maxv  = img_val[a];
    e.corr  = (a == int'(tgt));
`ifdef ACCURACY_COUNT_EN
    if (clr) begin
      model_img  = 0;
      model_corr = 0;
    end else begin
      model_img++;
      if (e.corr) model_corr++;
    end
    e.img  = model_img;
    e.ccnt = model_corr;
`else
    e.img  = 0;
    e.ccnt = 0;
`endif
    e.cyc = last_e0 + NOUT;
    sb.push_back(e);
  endtask

  task automatic clear_on_done_edge();
    while (cyc != last_e0 + NOUT - 1) @(negedge clk);
    clear_count = 1'b1;
    @(posedge clk);
    #1;
    clear_count = 1'b0;
  endtask

  task automatic finish_image();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL result_timeout actual=%0d_pending expected=0_pending", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic fill_random();
    logic [63:0] tmp64;
    int s;
    for (int i = 0; i < NOUT; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        tmp64 = {$urandom(), $urandom()};
        img_val[i] = tmp64[OWBITS-1:0];
      end else begin
        s = $urandom_range(0, 8) - 4;
        img_val[i] = OWBITS'(s);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_predicted_label"}, 64'(predicted_label), 64'd0);
    chk({tag, "_max_value"}, 64'(max_value), 64'd0);
    chk({tag, "_correct"}, 64'(correct), 64'd0);
    chk({tag, "_result_valid"}, 64'(result_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_image_count"}, 64'(image_count), 64'd0);
    chk({tag, "_correct_count"}, 64'(correct_count), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NOUT-1:0] m;
    logic [3:0]      tgt;
    int              slot [NOUT];

    reset_b           = 1'b0;
    end_state2        = '0;
    output_neuron_bus = '0;
    target_label      = '0;
    clear_count       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(posedge clk);

    // All cells on one edge; clear winner at index 2.
    img_val[0] = 5; img_val[1] = -3; img_val[2] = 900; img_val[3] = 7;
    for (int i = 4; i < NOUT; i++) img_val[i] = 0;
    target_label = 4'd2;
    pulse_cells('1);
    expect_result(4'd2, 1'b0);
    finish_image();

    // Staggered every third cycle, winner at the last cell, wrong target.
    for (int i = 0; i < NOUT; i++) img_val[i] = -100;
    img_val[NOUT-1] = -99;
    target_label = 4'd4;
    for (int i = 0; i < NOUT; i++) begin
      m = '0;
      m[i] = 1'b1;
      pulse_cells(m);
      if (i < NOUT - 1) repeat (2) @(posedge clk);
    end
    expect_result(4'd4, 1'b0);
    finish_image();

    // Tie between cells 3 and 7.
    for (int i = 0; i < NOUT; i++) img_val[i] = -5;
    img_val[3] = 42;
    img_val[7] = 42;
    target_label = 4'd3;
    pulse_cells('1);
    expect_result(4'd3, 1'b0);
    finish_image();

    // Cell 0 reports twice; the later value must win.
    for (int i = 0; i < NOUT; i++) img_val[i] = 0;
    img_val[0] = 10;
    target_label = 4'd0;
    pulse_cells(10'b1);
    img_val[0] = 1000;
    pulse_cells(10'b1);
    pulse_cells(~10'b1);
    expect_result(4'd0, 1'b0);
    finish_image();

    // Pulse during SCAN: ignored, overrun sticky.
    chk("overrun_before", 64'(overrun), 64'd0);
    fill_random();
    target_label = 4'd1;
    pulse_cells('1);
    expect_result(4'd1, 1'b0);
    img_val[5] = 50'sh0FFFFFFFFFFFF;
    pulse_cells(10'b0000100000);
    finish_image();
    chk("overrun_set", 64'(overrun), 64'd1);

    // Randomized images with random arrival grouping.
    for (int n = 0; n < 8; n++) begin
      fill_random();
      for (int i = 0; i < NOUT; i++) slot[i] = $urandom_range(0, 4);
      tgt = ($urandom_range(0, 1) == 1) ? 4'(ref_argmax()) : 4'($urandom_range(0, 9));
      target_label = tgt;
      for (int s = 0; s < 5; s++) begin
        m = '0;
        for (int i = 0; i < NOUT; i++) if (slot[i] == s) m[i] = 1'b1;
        if (m != '0) pulse_cells(m);
      end
      expect_result(tgt, 1'b0);
      finish_image();
    end
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Three images, counter clear on the second image's completing edge.
    for (int n = 0; n < 3; n++) begin
      fill_random();
      tgt = 4'(ref_argmax());
      target_label = tgt;
      pulse_cells('1);
      expect_result(tgt, n == 1);
      if (n == 1) clear_on_done_edge();
      finish_image();
    end

    // Reset in the middle of SCAN: everything returns to zero, no result.
    fill_random();
    target_label = 4'd0;
    pulse_cells('1);
    repeat (3) @(posedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    model_img  = 0;
    model_corr = 0;
    @(negedge clk);
    reset_b = 1'b1;
    repeat (NOUT + 5) @(posedge clk);

    // Recovery image after reset.
    fill_random();
    tgt = 4'(ref_argmax());
    target_label = tgt;
    pulse_cells('1);
    expect_result(tgt, 1'b0);
    finish_image();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
